// File: rtl/e_cd_debounce.sv
// Card-detect / write-protect pin qualifier: synchronisers, debounced insert/remove FSM, card power gate.
// Optional macro E_CD_WP_FILTER_EN adds a DB_CYCLES glitch filter on wp_level.
module e_cd_debounce #(
  parameter int unsigned DB_CYCLES = 32'd50000,
  parameter int unsigned DB_CNT_W  = 32'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic cd,
  input  logic wp,
  input  logic sd_pon,
  output logic cd_level,
  output logic wp_level,
  output logic card_stable,
  output logic card_inserted,
  output logic insert_pulse,
  output logic remove_pulse,
  output logic pon
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 32'd1);
  localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(32'd1);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_REMOVED  = 3'd1,
    ST_INS_PEND = 3'd2,
    ST_INSERTED = 3'd3,
    ST_REM_PEND = 3'd4
  } state_e;

  logic                cd_meta_r, cd_sync_r, wp_meta_r, wp_sync_r;
  state_e              state_r, state_s;
  logic [DB_CNT_W-1:0] cnt_r, cnt_s;
  logic                tgt_r, tgt_s;
  logic                stable_r, stable_s;
  logic                inserted_r, inserted_s;
  logic                ins_pulse_r, ins_pulse_s;
  logic                rem_pulse_r, rem_pulse_s;
  logic                pon_r;

  // Pin synchronisers; both chains idle high so a missing card is assumed until proven otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_meta_r <= 1'b1;
      cd_sync_r <= 1'b1;
      wp_meta_r <= 1'b1;
      wp_sync_r <= 1'b1;
    end else begin
      cd_meta_r <= cd;
      cd_sync_r <= cd_meta_r;
      wp_meta_r <= wp;
      wp_sync_r <= wp_meta_r;
    end
  end

  // Debounce next-state, counter and next-output logic; the counter is zero unless explicitly advanced.
  always_comb begin
    state_s     = state_r;
    cnt_s       = '0;
    tgt_s       = tgt_r;
    ins_pulse_s = 1'b0;
    rem_pulse_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (cd_sync_r != tgt_r) begin
          tgt_s = cd_sync_r;
        end else if (cnt_r == CNT_LAST) begin
          state_s = cd_sync_r ? ST_REMOVED : ST_INSERTED;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_REMOVED: begin
        if (!cd_sync_r) begin
          state_s = ST_INS_PEND;
        end else begin
          state_s = ST_REMOVED;
        end
      end
      ST_INS_PEND: begin
        if (cd_sync_r) begin
          state_s = ST_REMOVED;
        end else if (cnt_r == CNT_LAST) begin
          state_s     = ST_INSERTED;
          ins_pulse_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_INSERTED: begin
        if (cd_sync_r) begin
          state_s = ST_REM_PEND;
        end else begin
          state_s = ST_INSERTED;
        end
      end
      ST_REM_PEND: begin
        if (!cd_sync_r) begin
          state_s = ST_INSERTED;
        end else if (cnt_r == CNT_LAST) begin
          state_s     = ST_REMOVED;
          rem_pulse_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
    stable_s   = (state_s == ST_REMOVED) || (state_s == ST_INSERTED);
    inserted_s = (state_s == ST_INSERTED) || (state_s == ST_REM_PEND);
  end

  // FSM state and registered status/event outputs; power follows the committed card flag one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= '0;
      tgt_r       <= 1'b1;
      stable_r    <= 1'b0;
      inserted_r  <= 1'b0;
      ins_pulse_r <= 1'b0;
      rem_pulse_r <= 1'b0;
      pon_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tgt_r       <= tgt_s;
      stable_r    <= stable_s;
      inserted_r  <= inserted_s;
      ins_pulse_r <= ins_pulse_s;
      rem_pulse_r <= rem_pulse_s;
      pon_r       <= sd_pon & inserted_r;
    end
  end

`ifdef E_CD_WP_FILTER_EN
  logic                wp_lvl_r;
  logic [DB_CNT_W-1:0] wp_cnt_r;

  // Write-protect glitch filter: commit only after DB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_lvl_r <= 1'b1;
      wp_cnt_r <= '0;
    end else if (wp_sync_r == wp_lvl_r) begin
      wp_cnt_r <= '0;
    end else if (wp_cnt_r == CNT_LAST) begin
      wp_lvl_r <= wp_sync_r;
      wp_cnt_r <= '0;
    end else begin
      wp_cnt_r <= wp_cnt_r + CNT_ONE;
    end
  end

  assign wp_level = wp_lvl_r;
`else
  assign wp_level = wp_sync_r;
`endif

  assign cd_level      = cd_sync_r;
  assign card_stable   = stable_r;
  assign card_inserted = inserted_r;
  assign insert_pulse  = ins_pulse_r;
  assign remove_pulse  = rem_pulse_r;
  assign pon           = pon_r;

endmodule

// File: tb/tb_e_cd_debounce.sv
// Randomised bench for e_cd_debounce against a run-length reference model (DB_CYCLES = 4).
// Honours E_CD_WP_FILTER_EN so it matches whichever build of the design it is compiled with.
module tb_e_cd_debounce;

  localparam int unsigned DB = 32'd4;

  logic clk = 1'b0;
  logic rst, cd, wp, sd_pon;
  logic cd_level, wp_level, card_stable, card_inserted, insert_pulse, remove_pulse, pon;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  e_cd_debounce #(.DB_CYCLES(DB), .DB_CNT_W(32'd4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cd            (cd),
    .wp            (wp),
    .sd_pon        (sd_pon),
    .cd_level      (cd_level),
    .wp_level      (wp_level),
    .card_stable   (card_stable),
    .card_inserted (card_inserted),
    .insert_pulse  (insert_pulse),
    .remove_pulse  (remove_pulse),
    .pon           (pon)
  );

  // Reference model: committed card status plus the run length of the synchronised cd level.
  bit m_cd_meta, m_cd_lvl, m_wp_meta, m_wp_sync, m_wp_lvl;
  bit m_known, m_ins, m_stable, m_ipulse, m_rpulse, m_pon, m_last_l;
  int m_run, m_need, m_wp_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cd_meta = 1'b1; m_cd_lvl = 1'b1; m_wp_meta = 1'b1; m_wp_sync = 1'b1; m_wp_lvl = 1'b1;
    m_known = 1'b0; m_ins = 1'b0; m_stable = 1'b0; m_ipulse = 1'b0; m_rpulse = 1'b0;
    m_pon = 1'b0; m_last_l = 1'b1;
    m_run = 0; m_need = int'(DB); m_wp_run = 0;
  endtask

  task automatic model_edge();
    bit l, w;
    l = m_cd_lvl;
    w = m_wp_sync;
    m_pon = sd_pon & m_ins;
    m_ipulse = 1'b0;
    m_rpulse = 1'b0;
    if (l == m_last_l) begin
      m_run++;
    end else begin
      m_run = 1;
      m_last_l = l;
      if (!m_known) m_need = int'(DB) + 1;
    end
    if (!m_known) begin
      if (m_run == m_need) begin
        m_known = 1'b1;
        m_ins = !l;
      end
    end else if (!m_ins && !l && m_run == int'(DB) + 1) begin
      m_ins = 1'b1;
      m_ipulse = 1'b1;
    end else if (m_ins && l && m_run == int'(DB) + 1) begin
      m_ins = 1'b0;
      m_rpulse = 1'b1;
    end
    m_stable = m_known && (l == !m_ins);
    m_cd_lvl = m_cd_meta;
    m_cd_meta = cd;
    m_wp_sync = m_wp_meta;
    m_wp_meta = wp;
`ifdef E_CD_WP_FILTER_EN
    if (w != m_wp_lvl) begin
      m_wp_run++;
      if (m_wp_run == int'(DB)) begin
        m_wp_lvl = w;
        m_wp_run = 0;
      end
    end else begin
      m_wp_run = 0;
    end
`else
    m_wp_lvl = m_wp_sync;
`endif
  endtask

  task automatic check_all();
    chk("cd_level",      32'(cd_level),      32'(m_cd_lvl));
    chk("wp_level",      32'(wp_level),      32'(m_wp_lvl));
    chk("card_stable",   32'(card_stable),   32'(m_stable));
    chk("card_inserted", 32'(card_inserted), 32'(m_ins));
    chk("insert_pulse",  32'(insert_pulse),  32'(m_ipulse));
    chk("remove_pulse",  32'(remove_pulse),  32'(m_rpulse));
    chk("pon",           32'(pon),           32'(m_pon));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asserts reset between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset(input int hold);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (hold) cycle();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int hold;
    rst = 1'b0; cd = 1'b0; wp = 1'b1; sd_pon = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // Card present at power-up: INIT commits straight to inserted without a pulse.
    repeat (12) cycle();
    chk("init_inserted", 32'(card_inserted), 32'd1);
    chk("init_stable",   32'(card_stable),   32'd1);

    // Empty socket at power-up, then a clean insertion.
    cd = 1'b1;
    do_reset(1);
    repeat (12) cycle();
    chk("init_removed", 32'(card_inserted), 32'd0);
    cd = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!insert_pulse && n < 20);
    chk("insert_latency", 32'(n), 32'd7);
    cycle();
    chk("insert_pulse_width", 32'(insert_pulse), 32'd0);
    chk("pon_after_insert",   32'(pon),          32'd1);

    // Clean removal with power requested.
    repeat (3) cycle();
    cd = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!remove_pulse && n < 20);
    chk("remove_latency", 32'(n), 32'd7);
    chk("pon_held_at_remove", 32'(pon), 32'd1);
    cycle();
    chk("removed_flag",     32'(card_inserted), 32'd0);
    chk("pon_after_remove", 32'(pon),           32'd0);

    // Two-cycle bounce from REMOVED.
    repeat (3) cycle();
    cd = 1'b0;
    repeat (2) cycle();
    cd = 1'b1;
    repeat (10) cycle();
    chk("bounce_no_insert", 32'(card_inserted), 32'd0);

    // Reset during INS_PEND once the counter has reached 2.
    cd = 1'b0;
    repeat (5) cycle();
    chk("pend_before_reset", 32'(card_stable), 32'd0);
    do_reset(2);
    repeat (12) cycle();

    // Write-protect glitch, then a hold long enough to commit.
    wp = 1'b0;
    repeat (3) cycle();
    wp = 1'b1;
    repeat (8) cycle();
    wp = 1'b0;
    repeat (4) cycle();
    wp = 1'b1;
    repeat (8) cycle();

    // Random pin activity with occasional asynchronous resets.
    for (int s = 0; s < 400; s++) begin
      cd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) wp = ~wp;
      if ($urandom_range(0, 7) == 0) sd_pon = ~sd_pon;
      hold = int'($urandom_range(1, 10));
      if ($urandom_range(0, 59) == 0) do_reset(int'($urandom_range(1, 3)));
      repeat (hold) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/e_cd_debounce.md
# e_cd_debounce

Pin-side qualifier for the SDIO host card-detect path. Synchronises the raw `cd` and `wp` card-socket pins, debounces card insertion and removal with a counter-driven state machine, and gates card power. Drives the stable level, status and event signals consumed by `e_card_detect` and the host status/interrupt registers.

## Interface
- `DB_CYCLES`, default 16'd50000: consecutive stable `clk` cycles required to commit an insert/remove; legal range 2..2^`DB_CNT_W`.
- `DB_CNT_W`, default 16: debounce counter width.
- `clk`  in  1: system clock; all logic is single clock domain.
- `rst`  in  1: asynchronous, active-low reset.
- `cd`  in  1: raw card-detect pin, asynchronous; low = card present.
- `wp`  in  1: raw write-protect pin, asynchronous.
- `sd_pon`  in  1: host power-on request from the register block.
- `cd_level`  out  1: synchronised `cd`.
- `wp_level`  out  1: synchronised, and optionally filtered, `wp`.
- `card_stable`  out  1: high when the state machine is in a committed state.
- `card_inserted`  out  1: debounced card-present flag.
- `insert_pulse`  out  1: one-cycle strobe on a committed insertion.
- `remove_pulse`  out  1: one-cycle strobe on a committed removal.
- `pon`  out  1: card power enable, equal to `sd_pon & card_inserted`, registered.

## Operation
- Synchroniser: 2-flop chains for `cd` and `wp`. Both chains reset to 1. `cd_level` is the second `cd` flop.
- Counter `cnt[DB_CNT_W-1:0]`: cleared on every state transition and whenever `cd_level` does not match the current target level.
- States: INIT, REMOVED, INS_PEND, INSERTED, REM_PEND. Reset state is INIT.
- INIT: the target is the current `cd_level`. If `cd_level` changes, `cnt` clears and the new level becomes the target. When `cnt == DB_CYCLES-1`, the block moves to INSERTED if `cd_level` is 0, otherwise to REMOVED. No pulses are generated on leaving INIT.
- REMOVED: if `cd_level == 0`, go to INS_PEND.
- INS_PEND:
  - `cd_level == 1`: return to REMOVED with no pulse (bounce).
  - `cd_level == 0` and `cnt == DB_CYCLES-1`: go to INSERTED and assert `insert_pulse` for one cycle.
  - Otherwise: `cnt` increments.
- INSERTED: if `cd_level == 1`, go to REM_PEND.
- REM_PEND: mirror image of INS_PEND. A return of `cd_level` to 0 goes back to INSERTED with no pulse. Commit goes to REMOVED and asserts `remove_pulse`.
- `card_stable` is 1 in REMOVED and INSERTED, 0 in INIT and both PEND states.
- `card_inserted` is 1 in INSERTED and REM_PEND. It holds its committed value through pending states.
- `pon` deasserts the cycle after a removal commits, regardless of `sd_pon`. It never asserts while `card_inserted` is 0.
- `insert_pulse` and `remove_pulse` are mutually exclusive and never asserted together.
- `rst` asserted mid-debounce aborts the debounce immediately: the block returns to INIT, all outputs take reset values, and no pulse is produced.

## Timing
- Reset values:
  - `cd_level` = 1, `wp_level` = 1
  - `card_stable` = 0, `card_inserted` = 0
  - `insert_pulse` = 0, `remove_pulse` = 0, `pon` = 0
- Pin to `cd_level`: 2 clock edges.
- `cd_level` change to PEND entry: 1 edge.
- PEND entry to commit: `DB_CYCLES` edges when `cd_level` is held.
- Total latency from pin sample to `card_inserted`/pulse: `DB_CYCLES + 3` edges.
- `pon` follows `card_inserted` and `sd_pon` with 1 additional edge.
- A bounce of at least 1 cycle anywhere in a PEND state restarts the full `DB_CYCLES` window.

## Configuration
- `E_CD_WP_FILTER_EN` defined:
  - `wp_level` updates only after the synchronised `wp` has differed from `wp_level` for `DB_CYCLES` consecutive cycles.
  - Uses an independent `DB_CNT_W` counter, which clears on any match.
  - Total latency is `DB_CYCLES + 2` edges.
- `E_CD_WP_FILTER_EN` undefined: `wp_level` is the second `wp` synchroniser flop, with 2-edge latency and no counter.

## Test plan
- Reset release with `DB_CYCLES`=4, `cd`=0 held -> `card_stable` 0 until INIT commits, then `card_inserted`=1 and `card_stable`=1, with no `insert_pulse`.
- From REMOVED, `cd` 1->0 held, `DB_CYCLES`=4 -> `insert_pulse` high exactly 1 cycle, 7 edges after the sampling edge. `pon`=1 one edge later with `sd_pon`=1.
- From REMOVED, `cd` low for 2 cycles then high -> return to REMOVED, no pulse, `card_inserted` stays 0, `card_stable` dips for the bounce duration.
- From INSERTED with `sd_pon`=1, `cd` 0->1 held -> `remove_pulse` 1 cycle, `card_inserted`=0, `pon`=0 on the following edge.
- `rst` asserted in INS_PEND at `cnt`=2 -> all outputs at reset values asynchronously; no pulse after release until a full INIT window elapses.
- With `E_CD_WP_FILTER_EN`, `DB_CYCLES`=4: `wp` glitch of 3 cycles -> `wp_level` unchanged. 4-cycle hold -> `wp_level` toggles 6 edges after the sampling edge. Without the macro, the same glitch appears on `wp_level` delayed by 2 edges.
